mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (IF) and data load/store (d_r/d_w from controller).
//  Sequences each access through a 4-state FSM and returns data with a one-cycle ack.
//  Drives cpu_stall so the single-cycle datapath holds PC/regfile writes until its access completes.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles waiting for mem_ready before abort; 1..255, 8-bit counter
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active-low
//  if_req     in   1   fetch request, level, held until if_ack
//  if_addr    in   32  fetch address
//  if_ack     out  1   fetch complete, one-cycle pulse
//  if_rdata   out  32  fetched instruction, valid while if_ack
//  d_r        in   1   data read request, level, held until d_ack
//  d_w        in   1   data write request, level, held until d_ack
//  d_addr     in   32  data address
//  d_wdata    in   32  store data
//  d_ack      out  1   data access complete, one-cycle pulse
//  d_rdata    out  32  load data, valid while d_ack (0 for writes)
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write enable
//  mem_addr   out  32  memory address
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid with mem_ready
//  mem_ready  in   1   memory done; may be high in the same cycle mem_en rises
//  err        out  1   timeout/protocol error, one-cycle pulse with the ack
//  cpu_stall  out  1   (if_req|d_r|d_w) & ~(if_ack|d_ack), combinational
// BEHAVIOUR
//  Reset: state=IDLE; all outputs registered, 0; counter 0; last_grant=IF. Reset mid-access abandons it, no ack issued.
//  FSM: IDLE -> FETCH | DATA -> RESP -> IDLE.
//  IDLE: requests sampled only here. Only one pending -> grant it. Both pending -> round-robin: grant opposite of last_grant.
//   On grant latch addr/wdata/we into mem_* regs, set mem_en=1, clear counter, update last_grant.
//  FETCH/DATA: mem_* held stable; counter++ each cycle. mem_ready=1 -> latch mem_rdata, go RESP.
//   counter==TIMEOUT_CYC without mem_ready -> go RESP with rdata=0, err=1.
//  RESP: mem_en=mem_we=0; matching ack=1 for exactly this cycle with rdata; then IDLE.
//  Latency: req seen in IDLE cycle 0; mem_en cycle 1; ready at cycle k>=1 -> ack at k+1. Zero-wait memory: ack at cycle 2.
//  Requester drops req the cycle after ack; req still high in next IDLE = new access.
//  d_r & d_w together: perform write, d_rdata=0, err=1 with d_ack.
//  mem_ready outside FETCH/DATA ignored. Inputs changing mid-access ignored (latched copies used).
//  d_rdata/if_rdata hold last value outside ack; only sampled with ack.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs perf_if_cnt[31:0], perf_d_cnt[31:0] (grants, incremented on entering FETCH/DATA)
//   and perf_stall_cnt[31:0] (cycles with cpu_stall=1); all reset to 0, wrap 0xFFFFFFFF->0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Fetch only, mem_ready same cycle as mem_en, if_addr=0x00400000, mem_rdata=0x2008000A -> if_ack+if_rdata=0x2008000A at cycle 2, cpu_stall 1 on cycles 0..1.
//  Store d_w=1, d_addr=0x10010004, d_wdata=0xDEADBEEF, ready after 3 wait cycles -> mem_we=1 with that addr/data cycles 1..4, d_ack at 5, d_rdata=0.
//  if_req and d_r together from reset (last_grant=IF) -> DATA first, d_ack, then FETCH, if_ack; next contention grants IF first.
//  TIMEOUT_CYC=4, mem_ready stuck 0 on load -> d_ack+err at cycle 6, d_rdata=0, FSM back to IDLE, next fetch serviced normally.
//  rst_n low during DATA wait -> all outputs 0 asynchronously, no ack after release; d_r d_w both 1 -> write done, err=1 with d_ack.
//  ARB_PERF_CNT_EN: 3 fetches + 2 loads zero-wait -> perf_if_cnt=3, perf_d_cnt=2, perf_stall_cnt=10.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data load/store.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_r,
  input  logic        d_w,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_if_cnt,
  output logic [31:0] perf_d_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        cpu_stall
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_d_q, last_d_d;
  logic        both_q, both_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;

  logic        d_any;
  logic        grant_data;
  logic        grant_fetch;
  logic        done;

  assign d_any       = d_r | d_w;
  // With both pending, data wins only if the previous grant went to fetch.
  assign grant_data  = d_any & (~if_req | ~last_d_q);
  assign grant_fetch = if_req & ~grant_data;
  assign done        = mem_ready | (cnt_q == TimeoutLim);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    both_d      = both_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d     = S_DATA;
          mem_en_d    = 1'b1;
          mem_we_d    = d_w;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          both_d      = d_r & d_w;
          cnt_d       = '0;
          last_d_d    = 1'b1;
        end else if (grant_fetch) begin
          state_d     = S_FETCH;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          both_d      = 1'b0;
          cnt_d       = '0;
          last_d_d    = 1'b0;
        end
      end
      S_FETCH, S_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          state_d  = S_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (state_q == S_FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
            err_d      = ~mem_ready;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = (mem_ready & ~mem_we_q) ? mem_rdata : '0;
            err_d     = ~mem_ready | both_q;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      both_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      both_q      <= both_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign cpu_stall = (if_req | d_r | d_w) & ~(if_ack_q | d_ack_q);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_d_q, perf_d_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_if_d    = perf_if_q;
    perf_d_d     = perf_d_q;
    perf_stall_d = perf_stall_q;
    if (state_q == S_IDLE && grant_fetch) perf_if_d = perf_if_q + 32'd1;
    if (state_q == S_IDLE && grant_data)  perf_d_d  = perf_d_q + 32'd1;
    if (cpu_stall)                        perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q    <= '0;
      perf_d_q     <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_if_q    <= perf_if_d;
      perf_d_q     <= perf_d_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_if_cnt    = perf_if_q;
  assign perf_d_cnt     = perf_d_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
